// File: rtl/encoder83_pkg.sv
// Shared types, constants and the 74LS148-style encode function for encoder83_prio_sync.
package encoder83_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD} state_t;

  // {GS_, A_} sample that represents "no key pressed"
  localparam logic [3:0] NOKEY_SAMPLE = 4'b1111;

  localparam int unsigned DB_CYCLES_DEFAULT = 4;

  // Returns {A_[2:0], GS_, EO_}; later loop iterations override earlier, so the highest low line wins.
  function automatic logic [4:0] prio_enc148(input logic ei_n, input logic [7:0] i_n);
    logic [4:0] r;
    r = 5'b11111;
    if (!ei_n) begin
      r = 5'b11110;
      for (int n = 0; n < 8; n++) begin
        if (!i_n[n]) r = {~3'(n), 1'b0, 1'b1};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder83_prio_sync_stable_filter.sv
// Debounce filter: tracks a candidate {GS_,A_} sample and pulses once when it has been
// seen DB_CYCLES consecutive times.
module stable_filter
  import encoder83_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned DB_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sample,
  output logic [3:0] cand,
  output logic       stable_pulse
);

  logic [DB_W-1:0] cnt;

  // Pulse is registered alongside the count step that lands on DB_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand         <= NOKEY_SAMPLE;
      cnt          <= '0;
      stable_pulse <= 1'b0;
    end else if (sample != cand) begin
      cand         <= sample;
      cnt          <= '0;
      stable_pulse <= 1'b0;
    end else begin
      if (cnt != DB_W'(DB_CYCLES)) cnt <= cnt + 1'b1;
      stable_pulse <= (cnt == DB_W'(DB_CYCLES - 2));
    end
  end

endmodule

// File: rtl/encoder83_prio_sync.sv
// Synchronized, debounced 8-to-3 priority encoder (74LS148 pins) with a valid/ack key-code event.
// Optional overrun flag is built when ENCODER83_OVERRUN_EN is defined.
module encoder83_prio_sync
  import encoder83_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned DB_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EI_,
  input  logic [7:0] I_,
  output logic [2:0] A_,
  output logic       GS_,
  output logic       EO_,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ack
`ifdef ENCODER83_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  logic       ei_s1, ei_s2;
  logic [7:0] i_s1, i_s2;
  logic [4:0] enc;
  logic [3:0] sample;
  logic [3:0] cand;
  logic       stable_pulse;
  logic       cand_key;
  logic [2:0] cand_code;
  state_t     state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ei_s1 <= 1'b1;
      ei_s2 <= 1'b1;
      i_s1  <= 8'hFF;
      i_s2  <= 8'hFF;
      A_    <= 3'b111;
      GS_   <= 1'b1;
      EO_   <= 1'b1;
    end else begin
      ei_s1 <= EI_;
      ei_s2 <= ei_s1;
      i_s1  <= I_;
      i_s2  <= i_s1;
      {A_, GS_, EO_} <= enc;
    end
  end

  assign enc    = prio_enc148(ei_s2, i_s2);
  assign sample = {enc[1], enc[4:2]};

  // Filter sees the same sample the pin register captures, so it stays in step with {GS_,A_}.
  stable_filter #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_filter (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .cand         (cand),
    .stable_pulse (stable_pulse)
  );

  assign cand_key  = ~cand[3];
  assign cand_code = ~cand[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      code  <= '0;
      valid <= 1'b0;
`ifdef ENCODER83_OVERRUN_EN
      overrun <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (stable_pulse && cand_key) begin
            code  <= cand_code;
            valid <= 1'b1;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            valid <= 1'b0;
            state <= HOLD;
`ifdef ENCODER83_OVERRUN_EN
            overrun <= 1'b0;
`endif
          end
`ifdef ENCODER83_OVERRUN_EN
          else if (stable_pulse && cand_key && (cand_code != code)) begin
            overrun <= 1'b1;
          end
`else
          // a new stable key arriving before ack is dropped without trace
`endif
        end
        HOLD: begin
          // Only a release or a different key re-arms; the same key never repeats.
          if (stable_pulse) begin
            if (!cand_key) begin
              state <= IDLE;
            end else if (cand_code != code) begin
              code  <= cand_code;
              valid <= 1'b1;
              state <= WAIT_ACK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder83_prio_sync.sv
// Self-checking bench for encoder83_prio_sync: directed plan steps plus random key/ack traffic,
// compared every cycle against a behavioural model of pipeline delay, run-length debounce and events.
module tb_encoder83_prio_sync;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       EI_;
  logic [7:0] I_;
  logic [2:0] A_;
  logic       GS_;
  logic       EO_;
  logic [2:0] code;
  logic       valid;
  logic       ack;
`ifdef ENCODER83_OVERRUN_EN
  logic       overrun;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder83_prio_sync dut (
    .clk   (clk),
    .rst   (rst),
    .EI_   (EI_),
    .I_    (I_),
    .A_    (A_),
    .GS_   (GS_),
    .EO_   (EO_),
    .code  (code),
    .valid (valid),
    .ack   (ack)
`ifdef ENCODER83_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  // Reference model state
  logic       m_ei1, m_ei2;
  logic [7:0] m_i1, m_i2;
  logic [4:0] m_out;
  logic [3:0] m_last;
  int         m_run;
  bit         m_pulse;
  bit         m_valid, m_released, m_ovr;
  logic [2:0] m_code;

  // {A_, GS_, EO_}: scan from the top line down for the first pressed key.
  function automatic logic [4:0] ref_enc(input logic ei, input logic [7:0] i);
    if (ei) return 5'b11111;
    for (int n = 7; n >= 0; n--) begin
      if (i[n] == 1'b0) return {3'(7 - n), 1'b0, 1'b1};
    end
    return 5'b11110;
  endfunction

  task automatic model_reset();
    m_ei1 = 1'b1; m_ei2 = 1'b1; m_i1 = 8'hFF; m_i2 = 8'hFF;
    m_out = 5'b11111; m_last = 4'hF; m_run = 1; m_pulse = 0;
    m_valid = 0; m_released = 1; m_ovr = 0; m_code = 3'd0;
  endtask

  task automatic model_edge();
    logic [4:0] e;
    logic [3:0] v;
    logic       key;
    logic [2:0] c;
    key = ~m_last[3];
    c   = 3'(7 - int'(m_last[2:0]));
    if (m_valid) begin
      if (ack) begin
        m_valid = 0; m_released = 0; m_ovr = 0;
      end else if (m_pulse && key && c != m_code) begin
        m_ovr = 1;
      end
    end else if (m_pulse) begin
      if (!key) m_released = 1;
      else if (m_released || c != m_code) begin
        m_code = c; m_valid = 1;
      end
    end
    e = ref_enc(m_ei2, m_i2);
    v = {e[1], e[4:2]};
    m_run   = (v == m_last) ? m_run + 1 : 1;
    m_last  = v;
    m_pulse = (m_run == DB);
    m_out   = e;
    m_ei2 = m_ei1; m_i2 = m_i1;
    m_ei1 = EI_;   m_i1 = I_;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("A_", 8'(A_), 8'(m_out[4:2]));
    chk("GS_", 8'(GS_), 8'(m_out[1]));
    chk("EO_", 8'(EO_), 8'(m_out[0]));
    chk("code", 8'(code), 8'(m_code));
    chk("valid", 8'(valid), 8'(m_valid));
`ifdef ENCODER83_OVERRUN_EN
    chk("overrun", 8'(overrun), 8'(m_ovr));
`endif
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  // Reset asserted between edges, held across one edge, released away from the edge.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_A", 8'(A_), 8'h07);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; EI_ = 1'b1; I_ = 8'hFF; ack = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("reset_code", 8'(code), 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: enabled, no key
    EI_ = 1'b0;
    step(3);
    chk("t1_EO", 8'(EO_), 8'h00);
    chk("t1_GS", 8'(GS_), 8'h01);
    step(8);
    chk("t1_valid", 8'(valid), 8'h00);

    // 2: keys 4 and 2, event at edge 7, single ack, no repeat
    I_ = 8'b1110_1011;
    step(3);
    chk("t2_A", 8'(A_), 8'h03);
    chk("t2_GS", 8'(GS_), 8'h00);
    step(3);
    chk("t2_valid_e6", 8'(valid), 8'h00);
    step(1);
    chk("t2_valid_e7", 8'(valid), 8'h01);
    chk("t2_code", 8'(code), 8'h04);
    ack_pulse();
    chk("t2_ack", 8'(valid), 8'h00);
    step(12);
    chk("t2_norepeat", 8'(valid), 8'h00);

    // 3: release, then bounce on I_[6] shorter than the filter window
    I_ = 8'hFF;
    step(10);
    for (int k = 0; k < 5; k++) begin
      I_ = 8'hBF; step(2);
      I_ = 8'hFF; step(2);
    end
    step(12);
    chk("t3_valid", 8'(valid), 8'h00);
    chk("t3_code", 8'(code), 8'h04);

    // 4: new key 7 while code 4 awaits ack
    I_ = 8'hEF;
    step(8);
    chk("t4_code4", 8'(code), 8'h04);
    I_ = 8'h7F;
    step(10);
    chk("t4_frozen", 8'(code), 8'h04);
    ack_pulse();
    step(6);
    chk("t4_noevent", 8'(valid), 8'h00);
    I_ = 8'hFF;
    step(10);
    I_ = 8'h7F;
    step(8);
    chk("t4_code7", 8'(code), 8'h07);
    chk("t4_valid7", 8'(valid), 8'h01);

    // 5: disable while an event is pending
    EI_ = 1'b1;
    step(3);
    chk("t5_A", 8'(A_), 8'h07);
    chk("t5_EO", 8'(EO_), 8'h01);
    ack_pulse();
    step(10);
    EI_ = 1'b0;
    step(10);
    I_ = 8'hFF;
    step(10);

    // 6: reset mid-debounce and with an event pending
    I_ = 8'hFB;
    step(4);
    pulse_reset();
    step(6);
    chk("t6_e6", 8'(valid), 8'h00);
    step(1);
    chk("t6_e7", 8'(valid), 8'h01);
    chk("t6_code", 8'(code), 8'h02);
    pulse_reset();
    step(10);
    I_ = 8'hFF;
    step(10);

    // ack held high across an event
    ack = 1'b1;
    I_ = 8'hFD;
    step(12);
    ack = 1'b0;
    I_ = 8'hFF;
    step(10);

    // Random traffic with random holds and acks
    for (int r = 0; r < 300; r++) begin
      int hold;
      EI_  = ($urandom_range(9, 0) == 0);
      I_   = ($urandom_range(1, 0) == 0) ? 8'hFF : 8'($urandom);
      hold = $urandom_range(8, 1);
      for (int h = 0; h < hold; h++) begin
        ack = ($urandom_range(2, 0) == 0);
        step(1);
      end
    end
    ack = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder83_prio_sync.md
Name:
encoder83_prio_sync

Overview:
- 8-line-to-3-line priority encoder with 74LS148 pin semantics: active-low inputs I_, active-low enable EI_, outputs A_, GS_ and EO_.
- It is the encode-side counterpart of the 3-8 decoder in the exam designs.
- Adds a 2-flop input synchronizer, a debounce filter and a valid/ack event handshake, so that asynchronous key or switch lines produce exactly one code event per stable press.
- Sits between board push-buttons and the control logic that consumes key codes.

Parameters:
- DB_CYCLES, 4: number of consecutive identical registered samples required before a value is declared stable. Legal range is 2 to 255.
- DB_W, 8: width of the debounce counter. DB_W must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- EI_  in  1  enable, active-low, asynchronous to clk.
- I_  in  8  key lines, active-low, asynchronous. I_[7] has the highest priority.
- A_  out  3  encoded index, active-low (A_ = ~n). Registered.
- GS_  out  1  group select, low when enabled and any I_ is low. Registered.
- EO_  out  1  enable out, low when enabled and all I_ are high. Registered.
- code  out  3  latched event code, true polarity.
- valid  out  1  high while an unacknowledged event is held in code.
- ack  in  1  consumer acknowledge. Sampled only while valid is high.

Behaviour:
- Reset values (asynchronous):
  - both synchronizer stages of I_ and EI_ = all 1s;
  - A_=3'b111, GS_=1, EO_=1, code=0, valid=0;
  - counter=0, state=IDLE.
- Encode function, applied to the synchronized inputs:
  - EI_=1: A_=111, GS_=1, EO_=1.
  - EI_=0 and I_=8'hFF: A_=111, GS_=1, EO_=0.
  - otherwise n = highest index with I_[n]=0: A_=~n, GS_=0, EO_=1.
- Pin latency: a pin change set up before edge 0 appears on A_/GS_/EO_ after edge 3 (2 sync stages + 1 output register).
- Debounce filter:
  - Compares the registered sample S={GS_,A_} against a candidate value each cycle.
  - On a mismatch: load the candidate with S and clear the counter.
  - On a match: increment the counter, saturating at DB_CYCLES.
  - stable_pulse is a one-cycle pulse when the counter reaches DB_CYCLES-1.
  - A pin change held steady produces stable_pulse at edge 3+DB_CYCLES-1. valid rises after edge 3+DB_CYCLES, which is edge 7 at the default setting.
- FSM states: IDLE, WAIT_ACK, HOLD.
  - IDLE: stable_pulse with candidate GS_=0 → code=~candidate A_, valid=1, go to WAIT_ACK. A stable no-key value stays in IDLE.
  - WAIT_ACK: ack=1 → valid=0 on the next edge, go to HOLD. Filter activity is ignored here; code stays frozen.
  - HOLD:
    - stable no-key (GS_=1) → IDLE.
    - stable key with a code different from the current code → latch the new code, valid=1, go to WAIT_ACK.
    - stable key with the same code → stay in HOLD. No repeat events.
- ack while valid=0 is ignored.
- ack held high continuously: exactly one cycle of effect per event. valid is high for at least 1 cycle.
- EI_ going high acts as "no key" (GS_=1), so it behaves as a release.
- Bounce shorter than DB_CYCLES: no event, and code/valid are unchanged.
- A change mid-count restarts the count from 0.
- rst asserted at any point returns everything to the reset values immediately. A pending event is discarded.

Optional Feature:
- Macro: ENCODER83_OVERRUN_EN.
- Defined:
  - Adds output overrun (1 bit, reset 0).
  - overrun sets sticky when stable_pulse reports a key with a code ≠ code while in WAIT_ACK.
  - overrun clears on the same edge that ack is accepted.
  - The dropped code is not stored.
- Undefined: the port is absent and such events are silently ignored.

Decomposition:
- Package encoder83_pkg holds:
  - state enum {IDLE, WAIT_ACK, HOLD};
  - constant NOKEY_SAMPLE = 4'b1111 ({GS_,A_});
  - default DB_CYCLES;
  - pure function prio_enc148(EI_, I_) returning {A_, GS_, EO_}.
- One sub-module: stable_filter (candidate register, counter, stable_pulse output), parameterized by DB_CYCLES and DB_W.

Test Plan:
1. Reset, then EI_=0, I_=8'hFF → A_=111, GS_=1, EO_=0 after edge 3; valid stays 0.
2. EI_=0, I_ set to 8'b1110_1011 (I_[4] and I_[2] low), held steady; DB_CYCLES=4 → A_=3'b011, GS_=0 after edge 3; valid=1 with code=4 after edge 7; pulse ack=1 for one cycle → valid=0 next edge; keep holding → no second event.
3. I_[6] toggles low/high every 2 cycles for 20 cycles, then returns to 8'hFF → GS_ toggles, valid never rises, code unchanged.
4. While WAIT_ACK with code=4, change I_ to only I_[7] low and hold 10 cycles:
   - code stays 4;
   - with ENCODER83_OVERRUN_EN, overrun=1, cleared on ack;
   - after ack the FSM is in HOLD, the filter is already stable on 7, and no event is generated. Release to 8'hFF, then press I_[7] → code=7.
5. Key held (valid=1), drive EI_=1 → A_=111, GS_=1, EO_=1 after edge 3; ack, then release path to IDLE.
6. Assert rst for 1 cycle mid-debounce and again while valid=1 → all outputs at reset values immediately; a subsequent steady press produces valid at edge 7 relative to the deassertion of rst.
